// File: rtl/wb_mcb_bridge.sv
// Wishbone slave to Spartan-6 MCB user-port bridge.
// Single-word accesses with one access outstanding. Write data is pushed
// one cycle ahead of its command. Reads time out with a Wishbone error.
// Words that arrive after a timeout are counted as stale and are discarded.
// MCB error/underrun/overflow strobes are latched into sticky status bits.
module wb_mcb_bridge #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 1024
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic                    wb_we_i,
   input  logic [SELECT_WIDTH-1:0] wb_sel_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_cyc_i,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,

   output logic                    mcb_cmd_clk,
   output logic                    mcb_cmd_en,
   output logic [2:0]              mcb_cmd_instr,
   output logic [5:0]              mcb_cmd_bl,
   output logic [ADDR_WIDTH-1:0]   mcb_cmd_byte_addr,
   input  logic                    mcb_cmd_full,

   output logic                    mcb_wr_clk,
   output logic                    mcb_wr_en,
   output logic [SELECT_WIDTH-1:0] mcb_wr_mask,
   output logic [DATA_WIDTH-1:0]   mcb_wr_data,
   input  logic                    mcb_wr_full,
   input  logic                    mcb_wr_underrun,
   input  logic                    mcb_wr_error,

   output logic                    mcb_rd_clk,
   output logic                    mcb_rd_en,
   input  logic [DATA_WIDTH-1:0]   mcb_rd_data,
   input  logic                    mcb_rd_empty,
   input  logic                    mcb_rd_overflow,
   input  logic                    mcb_rd_error,

   input  logic                    status_clr,
   output logic [4:0]              status_o
);

   // Timer only needs to count up to TIMEOUT-1.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_CMD  = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   state_t                  state;
   logic [3:0]              stale;
   logic [3:0]              stale_next;
   logic [TW-1:0]           timer;

   logic                    req;
   logic                    discard;
   logic                    rsp;
   logic                    tmo;
   logic [ADDR_WIDTH-1:0]   adr_al;

   // The MCB port runs on the bridge clock.
   assign mcb_cmd_clk = clk;
   assign mcb_wr_clk  = clk;
   assign mcb_rd_clk  = clk;
   assign mcb_cmd_bl  = 6'd0;

   // A new request is ignored while its own termination is still showing.
   assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign adr_al = wb_adr_i & ~ADDR_WIDTH'(SELECT_WIDTH - 1);

   // Pop whenever stale words are owed, or when a read is waiting on its word.
   assign mcb_rd_en = ~mcb_rd_empty & ((stale != 4'd0) | (state == RD_WAIT));
   assign discard   = mcb_rd_en & (stale != 4'd0);
   assign rsp       = mcb_rd_en & (stale == 4'd0) & (state == RD_WAIT);
   // A response arriving in the expiry cycle takes priority over the timeout.
   assign tmo       = (TIMEOUT != 0) && (state == RD_WAIT) &&
                      (timer == TW'(TIMEOUT - 1)) && !rsp;

   // Stale count: minus one per discarded word, plus one per timeout, saturating at 15.
   always_comb begin
      stale_next = stale;
      if (discard)
         stale_next = stale_next - 4'd1;
      if (tmo && (stale_next != 4'hF))
         stale_next = stale_next + 4'd1;
   end

   // Access sequencer: drives the MCB command/write pushes and the Wishbone terminations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         stale             <= 4'd0;
         timer             <= '0;
         wb_dat_o          <= '0;
         wb_ack_o          <= 1'b0;
         wb_err_o          <= 1'b0;
         mcb_cmd_en        <= 1'b0;
         mcb_cmd_instr     <= 3'b000;
         mcb_cmd_byte_addr <= '0;
         mcb_wr_en         <= 1'b0;
         mcb_wr_mask       <= '0;
         mcb_wr_data       <= '0;
      end else begin
         wb_ack_o   <= 1'b0;
         wb_err_o   <= 1'b0;
         mcb_cmd_en <= 1'b0;
         mcb_wr_en  <= 1'b0;
         stale      <= stale_next;
         case (state)
            IDLE: begin
               if (req) begin
                  if (wb_we_i) begin
                     if (!mcb_cmd_full && !mcb_wr_full) begin
                        mcb_wr_en   <= 1'b1;
                        mcb_wr_data <= wb_dat_i;
                        mcb_wr_mask <= ~wb_sel_i;
                        state       <= WR_CMD;
                     end
                  end else if (!mcb_cmd_full && (stale != 4'hF)) begin
                     mcb_cmd_en        <= 1'b1;
                     mcb_cmd_instr     <= 3'b001;
                     mcb_cmd_byte_addr <= adr_al;
                     timer             <= '0;
                     state             <= RD_WAIT;
                  end
               end
            end
            WR_CMD: begin
               // The data word is already in the write FIFO; now issue its command.
               mcb_cmd_en        <= 1'b1;
               mcb_cmd_instr     <= 3'b000;
               mcb_cmd_byte_addr <= adr_al;
               wb_ack_o          <= 1'b1;
               state             <= IDLE;
            end
            RD_WAIT: begin
               timer <= timer + 1'b1;
               if (rsp) begin
                  // An abandoned cycle still consumes its word but is not terminated.
                  wb_dat_o <= mcb_rd_data;
                  wb_ack_o <= wb_cyc_i & wb_stb_i;
                  state    <= IDLE;
               end else if (tmo) begin
                  wb_err_o <= wb_cyc_i & wb_stb_i;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky status flags; a set in the same cycle as a clear survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         status_o <= 5'd0;
      else
         status_o <= (status_clr ? 5'd0 : status_o) |
                     {tmo, mcb_rd_error, mcb_rd_overflow, mcb_wr_error, mcb_wr_underrun};
   end

endmodule
